// File: rtl/pong_pkg.sv
// Shared pong definitions: screen/paddle geometry defaults, ball FSM encoding
// and a vertical-overlap helper used by the paddle collision logic.
package pong_pkg;

  localparam int unsigned POS_W = 10;
  localparam int unsigned SUM_W = 11;

  localparam int unsigned PONG_SCREEN_W      = 640;
  localparam int unsigned PONG_SCREEN_H      = 480;
  localparam int unsigned PONG_BALL_SIZE     = 10;
  localparam int unsigned PONG_PADDLE_W      = 10;
  localparam int unsigned PONG_PADDLE_H      = 60;
  localparam int unsigned PONG_LEFT_PADDLE_X = 20;
  localparam int unsigned PONG_RIGHT_PADDLE_X = 610;
  localparam int unsigned PONG_STEP          = 2;
  localparam int unsigned PONG_MAX_STEP      = 8;
  localparam int unsigned PONG_HOLD_FRAMES   = 60;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } ball_state_e;

  // True when a ball at y vertically overlaps a paddle whose top edge is paddle_y.
  function automatic logic y_overlap(
    input logic [SUM_W-1:0] y,
    input logic [SUM_W-1:0] paddle_y,
    input logic [SUM_W-1:0] ball_size,
    input logic [SUM_W-1:0] paddle_h
  );
    return ((y + ball_size) > paddle_y) && (y < (paddle_y + paddle_h));
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// Single-axis wall reflect/clamp: advances pos by step in the current direction,
// clamping at 0 or LIMIT-SIZE and flipping direction when a wall is reached.
module ball_axis_step
  import pong_pkg::*;
#(
  parameter int unsigned LIMIT  = PONG_SCREEN_H,
  parameter int unsigned SIZE   = PONG_BALL_SIZE,
  parameter int unsigned STEP_W = 4
) (
  input  logic [POS_W-1:0]  pos,
  input  logic              dir_pos,
  input  logic [STEP_W-1:0] step,
  output logic [POS_W-1:0]  pos_next_c,
  output logic              dir_pos_next_c
);

  logic [SUM_W-1:0] pos_w;
  logic [SUM_W-1:0] step_w;

  assign pos_w  = SUM_W'(pos);
  assign step_w = SUM_W'(step);

  // Next position and direction after one step with wall clamping.
  always_comb begin
    pos_next_c     = pos;
    dir_pos_next_c = dir_pos;
    if (dir_pos) begin
      if ((pos_w + SUM_W'(SIZE) + step_w) > SUM_W'(LIMIT)) begin
        pos_next_c     = POS_W'(LIMIT - SIZE);
        dir_pos_next_c = 1'b0;
      end else begin
        pos_next_c = POS_W'(pos_w + step_w);
      end
    end else begin
      if (pos_w < step_w) begin
        pos_next_c     = '0;
        dir_pos_next_c = 1'b1;
      end else begin
        pos_next_c = POS_W'(pos_w - step_w);
      end
    end
  end

endmodule

// File: rtl/ball_controller.sv
// Pong ball motion controller: per-frame X/Y update, wall and paddle
// reflection, miss detection with score pulses, serve/hold sequencing.
// Optional build macro BALL_SPEEDUP_EN: each paddle hit raises the step
// by one up to MAX_STEP; the step resets to STEP when the ball re-centres.
module ball_controller
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W       = PONG_SCREEN_W,
  parameter int unsigned SCREEN_H       = PONG_SCREEN_H,
  parameter int unsigned BALL_SIZE      = PONG_BALL_SIZE,
  parameter int unsigned PADDLE_W       = PONG_PADDLE_W,
  parameter int unsigned PADDLE_H       = PONG_PADDLE_H,
  parameter int unsigned LEFT_PADDLE_X  = PONG_LEFT_PADDLE_X,
  parameter int unsigned RIGHT_PADDLE_X = PONG_RIGHT_PADDLE_X,
  parameter int unsigned STEP           = PONG_STEP,
  parameter int unsigned MAX_STEP       = PONG_MAX_STEP,
  parameter int unsigned HOLD_FRAMES    = PONG_HOLD_FRAMES
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] left_paddle_Y,
  input  logic [9:0] right_paddle_Y,
  output logic [9:0] ball_X_location,
  output logic [9:0] ball_Y_location,
  output logic       ball_active,
  output logic       score_left,
  output logic       score_right
);

  localparam int unsigned STEP_W = $clog2(MAX_STEP + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [POS_W-1:0]  CENTER_X   = POS_W'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0]  CENTER_Y   = POS_W'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0]  LEFT_FACE  = POS_W'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [POS_W-1:0]  RIGHT_STOP = POS_W'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [STEP_W-1:0] STEP_INIT  = STEP_W'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

  ball_state_e       state_q, state_d;
  logic [POS_W-1:0]  x_d, y_d;
  logic              dir_right_q, dir_right_d;
  logic              dir_down_q, dir_down_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              score_left_d, score_right_d, active_d;

  logic [POS_W-1:0]  y_step_c;
  logic              dir_down_step_c;
  logic [STEP_W-1:0] step_hit_c;
  logic [SUM_W-1:0]  x_w, y_w, step_w;
  logic              left_hit_c, left_miss_c, right_hit_c, right_miss_c;

  assign x_w    = SUM_W'(ball_X_location);
  assign y_w    = SUM_W'(ball_Y_location);
  assign step_w = SUM_W'(step_q);

  // Vertical motion with top/bottom wall reflection.
  ball_axis_step #(
    .LIMIT  (SCREEN_H),
    .SIZE   (BALL_SIZE),
    .STEP_W (STEP_W)
  ) u_y_axis (
    .pos            (ball_Y_location),
    .dir_pos        (dir_down_q),
    .step           (step_q),
    .pos_next_c     (y_step_c),
    .dir_pos_next_c (dir_down_step_c)
  );

  // Step after a paddle hit.
`ifdef BALL_SPEEDUP_EN
  assign step_hit_c = (step_q < STEP_W'(MAX_STEP)) ? step_q + STEP_W'(1) : step_q;
`else
  assign step_hit_c = step_q;
`endif

  // Paddle-face crossing and miss detection on the pre-update position.
  assign left_hit_c = (x_w >= SUM_W'(LEFT_FACE)) &&
                      (x_w < (SUM_W'(LEFT_FACE) + step_w)) &&
                      y_overlap(y_w, SUM_W'(left_paddle_Y),
                                SUM_W'(BALL_SIZE), SUM_W'(PADDLE_H));
  assign left_miss_c = x_w < step_w;
  assign right_hit_c = ((x_w + SUM_W'(BALL_SIZE)) <= SUM_W'(RIGHT_PADDLE_X)) &&
                       ((x_w + SUM_W'(BALL_SIZE) + step_w) > SUM_W'(RIGHT_PADDLE_X)) &&
                       y_overlap(y_w, SUM_W'(right_paddle_Y),
                                 SUM_W'(BALL_SIZE), SUM_W'(PADDLE_H));
  assign right_miss_c = (x_w + SUM_W'(BALL_SIZE) + step_w) > SUM_W'(SCREEN_W);

  // Next-state and next-output logic for the serve/move/hold sequence.
  always_comb begin
    state_d       = state_q;
    x_d           = ball_X_location;
    y_d           = ball_Y_location;
    dir_right_d   = dir_right_q;
    dir_down_d    = dir_down_q;
    step_d        = step_q;
    hold_cnt_d    = hold_cnt_q;
    score_left_d  = 1'b0;
    score_right_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serve) begin
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (frame_tick) begin
          y_d        = y_step_c;
          dir_down_d = dir_down_step_c;
          if (!dir_right_q) begin
            if (left_hit_c) begin
              x_d         = LEFT_FACE;
              dir_right_d = 1'b1;
              step_d      = step_hit_c;
            end else if (left_miss_c) begin
              // Freeze at the miss point; next rally heads back the other way.
              y_d           = ball_Y_location;
              dir_down_d    = dir_down_q;
              dir_right_d   = 1'b1;
              score_right_d = 1'b1;
              hold_cnt_d    = '0;
              state_d       = HOLD;
            end else begin
              x_d = POS_W'(x_w - step_w);
            end
          end else begin
            if (right_hit_c) begin
              x_d         = RIGHT_STOP;
              dir_right_d = 1'b0;
              step_d      = step_hit_c;
            end else if (right_miss_c) begin
              y_d          = ball_Y_location;
              dir_down_d   = dir_down_q;
              dir_right_d  = 1'b0;
              score_left_d = 1'b1;
              hold_cnt_d   = '0;
              state_d      = HOLD;
            end else begin
              x_d = POS_W'(x_w + step_w);
            end
          end
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            x_d        = CENTER_X;
            y_d        = CENTER_Y;
            step_d     = STEP_INIT;
            state_d    = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        x_d     = CENTER_X;
        y_d     = CENTER_Y;
        step_d  = STEP_INIT;
        state_d = IDLE;
      end
    endcase
    active_d = (state_d == MOVE);
  end

  // State, position and pulse registers.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ball_X_location <= CENTER_X;
      ball_Y_location <= CENTER_Y;
      dir_right_q     <= 1'b1;
      dir_down_q      <= 1'b1;
      step_q          <= STEP_INIT;
      hold_cnt_q      <= '0;
      ball_active     <= 1'b0;
      score_left      <= 1'b0;
      score_right     <= 1'b0;
    end else begin
      state_q         <= state_d;
      ball_X_location <= x_d;
      ball_Y_location <= y_d;
      dir_right_q     <= dir_right_d;
      dir_down_q      <= dir_down_d;
      step_q          <= step_d;
      hold_cnt_q      <= hold_cnt_d;
      ball_active     <= active_d;
      score_left      <= score_left_d;
      score_right     <= score_right_d;
    end
  end

endmodule

// File: tb/tb_ball_controller.sv
// Self-checking bench for ball_controller: directed rally scenarios followed by
// randomized serve/frame/paddle stimulus against a velocity-based ball model.
module tb_ball_controller;

  localparam int CX    = 315;
  localparam int CY    = 235;
  localparam int STEP  = 2;
  localparam int MAXS  = 8;
  localparam int HOLDF = 60;

  logic       pixel_clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] left_paddle_Y = 10'd0;
  logic [9:0] right_paddle_Y = 10'd0;
  logic [9:0] ball_X_location, ball_Y_location;
  logic       ball_active, score_left, score_right;

  int n_checks = 0;
  int n_errors = 0;

  // Model: position plus signed velocity signs; mode 0=centred,1=in play,2=paused.
  int  m_x, m_y, m_vx, m_vy, m_step, m_mode, m_hold, m_sl, m_sr;
  bit  speedup;

  ball_controller dut (
    .pixel_clk       (pixel_clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .serve           (serve),
    .left_paddle_Y   (left_paddle_Y),
    .right_paddle_Y  (right_paddle_Y),
    .ball_X_location (ball_X_location),
    .ball_Y_location (ball_Y_location),
    .ball_active     (ball_active),
    .score_left      (score_left),
    .score_right     (score_right)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_x = CX; m_y = CY; m_vx = 1; m_vy = 1; m_step = STEP;
    m_mode = 0; m_hold = 0; m_sl = 0; m_sr = 0;
  endfunction

  function automatic bit overlaps(input int y, input int p);
    return (y + 10 > p) && (y < p + 60);
  endfunction

  // One frame of play using signed arithmetic on the geometry rules.
  function automatic void model_frame(input int lp, input int rp);
    int ny, nvy, nx;
    bit hit, miss;
    if (m_mode == 1) begin
      nvy = m_vy;
      ny  = m_y + m_vy * m_step;
      if (ny < 0) begin ny = 0; nvy = 1; end
      else if (ny + 10 > 480) begin ny = 470; nvy = -1; end
      hit = 0; miss = 0;
      nx = m_x + m_vx * m_step;
      if (m_vx < 0) begin
        if (m_x >= 30 && nx < 30 && overlaps(m_y, lp)) begin nx = 30; hit = 1; end
        else if (nx < 0) miss = 1;
      end else begin
        if (m_x + 10 <= 610 && nx + 10 > 610 && overlaps(m_y, rp)) begin nx = 600; hit = 1; end
        else if (nx + 10 > 640) miss = 1;
      end
      if (miss) begin
        if (m_vx > 0) m_sl = 1; else m_sr = 1;
        m_vx = -m_vx; m_mode = 2; m_hold = 0;
      end else begin
        m_x = nx; m_y = ny; m_vy = nvy;
        if (hit) begin
          m_vx = -m_vx;
          if (speedup && m_step < MAXS) m_step++;
        end
      end
    end else if (m_mode == 2) begin
      m_hold++;
      if (m_hold == HOLDF) begin
        m_mode = 0; m_x = CX; m_y = CY; m_step = STEP;
      end
    end
  endfunction

  task automatic compare_all(input string pfx);
    check_eq({pfx, "_x"}, int'(ball_X_location), m_x);
    check_eq({pfx, "_y"}, int'(ball_Y_location), m_y);
    check_eq({pfx, "_active"}, int'(ball_active), (m_mode == 1) ? 1 : 0);
    check_eq({pfx, "_score_left"}, int'(score_left), m_sl);
    check_eq({pfx, "_score_right"}, int'(score_right), m_sr);
  endtask

  // Drive one input cycle, advance the model, then sample outputs after the edge.
  task automatic cycle(input bit ft, input bit sv, input int lp, input int rp, input string pfx);
    @(negedge pixel_clk);
    frame_tick = ft; serve = sv;
    left_paddle_Y = 10'(lp); right_paddle_Y = 10'(rp);
    m_sl = 0; m_sr = 0;
    if (sv && m_mode == 0) m_mode = 1;
    else if (ft) model_frame(lp, rp);
    @(negedge pixel_clk);
    frame_tick = 1'b0; serve = 1'b0;
    compare_all(pfx);
  endtask

  task automatic do_reset(input string pfx);
    @(negedge pixel_clk);
    reset = 1'b1; frame_tick = 1'b0; serve = 1'b0;
    @(negedge pixel_clk);
    model_reset();
    compare_all(pfx);
    reset = 1'b0;
  endtask

  int sl_count;
  int guard;

  initial begin
`ifdef BALL_SPEEDUP_EN
    speedup = 1'b1;
`else
    speedup = 1'b0;
`endif
    model_reset();
    do_reset("reset");

    // Idle frames do not move the centred ball.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 200, 400, "idle");
    check_eq("idle_x_centre", int'(ball_X_location), 315);

    // Serve with a coincident tick launches but does not move.
    cycle(1'b1, 1'b1, 200, 400, "serve_tick");
    check_eq("serve_tick_x", int'(ball_X_location), 315);
    cycle(1'b1, 1'b0, 200, 400, "tick1");
    check_eq("tick1_x", int'(ball_X_location), 317);
    check_eq("tick1_y", int'(ball_Y_location), 237);

    for (int t = 2; t <= 118; t++) cycle(1'b1, 1'b0, 200, 400, "run");
    check_eq("tick118_y_clamp", int'(ball_Y_location), 470);
    cycle(1'b1, 1'b0, 200, 400, "tick119");
    check_eq("tick119_y", int'(ball_Y_location), 468);
    for (int t = 120; t <= 143; t++) cycle(1'b1, 1'b0, 200, 400, "run");
    check_eq("tick143_x_hit", int'(ball_X_location), 600);
    check_eq("tick143_y", int'(ball_Y_location), 420);
    cycle(1'b1, 1'b0, 200, 400, "tick144");
    check_eq("tick144_x", int'(ball_X_location), speedup ? 597 : 598);

    // Right side misses: one score_left pulse, hold, re-centre, serve leftward.
    do_reset("reset2");
    cycle(1'b0, 1'b1, 200, 0, "serve2");
    sl_count = 0;
    guard = 0;
    while (m_mode == 1 && guard < 400) begin
      cycle(1'b1, 1'b0, 200, 0, "to_miss");
      if (score_left) sl_count++;
      guard++;
    end
    check_eq("miss_reached", guard < 400 ? 1 : 0, 1);
    check_eq("miss_x", int'(ball_X_location), 629);
    for (int i = 0; i < HOLDF - 1; i++) begin
      cycle(1'b1, 1'b0, 200, 0, "hold");
      if (score_left) sl_count++;
    end
    check_eq("score_left_pulses", sl_count, 1);
    check_eq("hold_x_frozen", int'(ball_X_location), 629);
    cycle(1'b1, 1'b0, 200, 0, "hold_end");
    check_eq("recentre_x", int'(ball_X_location), 315);
    check_eq("recentre_active", int'(ball_active), 0);
    cycle(1'b0, 1'b1, 200, 0, "serve3");
    cycle(1'b1, 1'b0, 200, 0, "serve3_tick");
    check_eq("serve_left_x", int'(ball_X_location), 313);

    // Reset in the middle of a hold.
    guard = 0;
    while (m_mode != 2 && guard < 2000) begin
      cycle(1'b1, 1'b0, 470, 470, "to_miss2");
      guard++;
    end
    check_eq("miss2_reached", guard < 2000 ? 1 : 0, 1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 470, 470, "hold2");
    do_reset("mid_hold_reset");
    cycle(1'b1, 1'b0, 0, 0, "after_reset");

    // Randomized play.
    for (int i = 0; i < 3500; i++) begin
      cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 420)), int'($urandom_range(0, 420)), "rand");
      if ($urandom_range(0, 999) == 0) do_reset("rand_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
